// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: serialises lane A then lane B onto one data-memory port
// and stalls the M stage until both accesses of the bundle complete.
// Optional counters: define MEM_ARB_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_to_reg_a,
  input  logic              mem_write_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              mem_to_reg_b,
  input  logic              mem_write_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              stall_m
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic [CNT_W-1:0]  wait_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_A = 2'd1,
    ACC_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   need_a, need_b;

  assign need_a  = mem_to_reg_a | mem_write_a;
  assign need_b  = mem_to_reg_b | mem_write_b;
  assign stall_m = (need_a | need_b) & (state != DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (need_a)      state_nxt = ACC_A;
        else if (need_b) state_nxt = ACC_B;
      end
      ACC_A: begin
        mem_req   = 1'b1;
        mem_we    = mem_write_a;
        mem_addr  = addr_a;
        mem_wdata = wdata_a;
        if (mem_ready) state_nxt = need_b ? ACC_B : DONE;
      end
      ACC_B: begin
        mem_req   = 1'b1;
        mem_we    = mem_write_b;
        mem_addr  = addr_b;
        mem_wdata = wdata_b;
        if (mem_ready) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A lane flagged as both load and store behaves as a store, so no capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (state == ACC_A && mem_ready && mem_to_reg_a && !mem_write_a)
        rdata_a <= mem_rdata;
      if (state == ACC_B && mem_ready && mem_to_reg_b && !mem_write_b)
        rdata_b <= mem_rdata;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt    <= '0;
      conflict_cnt <= '0;
      wait_cnt     <= '0;
    end else begin
      if (stall_m)
        stall_cnt <= stall_cnt + 1'b1;
      if (state == IDLE && need_a && need_b)
        conflict_cnt <= conflict_cnt + 1'b1;
      if (mem_req && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Memory-stage controller for the dual-issue pipeline.
- Shares the single data-memory port between issue lanes A and B, which are presented simultaneously by the execute-to-memory pipeline register.
- Serializes accesses in program order (A before B) over a variable-latency req/ready port.
- Drives stall_m, which freezes the memory pipeline register and everything upstream until both accesses of the bundle complete.

Parameters:
- ADDR_W, 32, width of the data-memory address.
- DATA_W, 32, width of the memory data and load results.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- mem_to_reg_a  input  1  lane A bundle is a load.
- mem_write_a  input  1  lane A bundle is a store.
- addr_a  input  ADDR_W  lane A address (ALU result).
- wdata_a  input  DATA_W  lane A store data.
- mem_to_reg_b, mem_write_b, addr_b, wdata_b  input  1/1/ADDR_W/DATA_W  lane B equivalents.
- mem_req  output  1  memory request.
- mem_we  output  1  request is a write.
- mem_addr  output  ADDR_W  request address.
- mem_wdata  output  DATA_W  request write data.
- mem_rdata  input  DATA_W  read data, valid when mem_req && mem_ready.
- mem_ready  input  1  completes the current request this cycle.
- rdata_a  output  DATA_W  lane A load result.
- rdata_b  output  DATA_W  lane B load result.
- stall_m  output  1  hold the M-stage register and upstream; wired to the pipeline Stall input.

Behaviour:
- Definitions: need_a = mem_to_reg_a | mem_write_a; need_b = mem_to_reg_b | mem_write_b.
- Lane inputs stay stable while stall_m=1; the pipeline register guarantees this.
- States: IDLE, ACC_A, ACC_B, DONE, encoded in a registered 2-bit state.
- IDLE:
  - need_a -> ACC_A.
  - else need_b -> ACC_B.
  - else stay in IDLE.
- ACC_A: mem_req=1, mem_we=mem_write_a, mem_addr=addr_a, mem_wdata=wdata_a. On mem_ready: need_b -> ACC_B, else -> DONE.
- ACC_B: same as ACC_A but driven from lane B fields. On mem_ready -> DONE.
- DONE: lasts one cycle, then -> IDLE. The bundle advances during this cycle.
- stall_m = (need_a | need_b) & (state != DONE). It is combinational from registered state and stable inputs.
- In IDLE, ACC_A and ACC_B the memory outputs are: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0 except as specified for the active ACC state. mem_req is held until mem_ready.
- mem_ready while mem_req=0 is ignored.
- Load capture:
  - In ACC_A with mem_ready && mem_to_reg_a, rdata_a <= mem_rdata on that edge.
  - In ACC_B the same applies to rdata_b.
  - Both results are otherwise held; a store never modifies them.
- Latency for a single access with ready in the first request cycle: 3 cycles (IDLE, ACC, DONE), 2 of them stalled.
- Latency for a dual access with immediate ready: 4 cycles, 3 of them stalled.
- Each extra wait cycle adds one stall cycle.
- Ordering: A always completes before B issues. A store in A followed by a load in B at the same address returns the stored data via memory; no forwarding is done in this block.
- Both need flags set on one lane (load and store together) is illegal input; the access is treated as a store with mem_we=1.
- Reset (synchronous) from any state:
  - state=IDLE, rdata_a=0, rdata_b=0.
  - mem_req drops on the next cycle; an outstanding request is abandoned.
  - mem_ready arriving after reset is ignored.
  - Reset to outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stall_m follows the need_a/need_b equation from IDLE.
- No bundle with need_a=need_b=0 ever stalls.

Optional Feature:
- Macro MEM_ARB_PERF_CNT_EN.
- Defined: adds outputs stall_cnt [CNT_W], conflict_cnt [CNT_W] and wait_cnt [CNT_W], all reset to 0 and wrapping modulo 2^CNT_W.
  - stall_cnt increments on each cycle with stall_m=1.
  - conflict_cnt increments once per bundle with need_a && need_b, on entry to ACC_A.
  - wait_cnt increments on each cycle with mem_req && !mem_ready.
- Undefined: ports and counters are absent; the behaviour above is unchanged.

Test Plan:
- No access (need_a=need_b=0) for 5 cycles -> stall_m=0 and mem_req=0 throughout; state stays IDLE.
- Lane A load, addr_a=0x100, memory returns 0xDEADBEEF with ready in the first request cycle -> stall_m=1 for 2 cycles, mem_req for 1 cycle with mem_addr=0x100 and mem_we=0, rdata_a=0xDEADBEEF, DONE on cycle 3.
- Dual access: A store 0x55 to 0x40, B load from 0x40, immediate ready -> A request then B request in order, rdata_b=0x55, 3 stall cycles.
- Lane B-only store with mem_ready delayed 3 cycles -> mem_req held for 4 cycles with stable addr/wdata; stall_m=1 for 5 cycles; rdata_a and rdata_b unchanged.
- Reset asserted in ACC_B mid-wait, then a late mem_ready -> next cycle state=IDLE, mem_req=0, rdata_a=rdata_b=0, the late ready has no effect.
- With MEM_ARB_PERF_CNT_EN defined, run the dual-access test with 2 wait cycles on A -> conflict_cnt=1, wait_cnt=2, stall_cnt=5.
